// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, coin values, the
// code-to-value mapping used by both coin detection and change payout,
// and the change dispenser state encoding.
package vm_pkg;

  localparam int unsigned NumDenoms = 4;

  localparam logic [3:0] CodeOne   = 4'h1;
  localparam logic [3:0] CodeFive  = 4'h2;
  localparam logic [3:0] CodeTen   = 4'h3;
  localparam logic [3:0] CodeFifty = 4'h4;

  localparam logic [7:0] ValOne   = 8'd1;
  localparam logic [7:0] ValFive  = 8'd5;
  localparam logic [7:0] ValTen   = 8'd10;
  localparam logic [7:0] ValFifty = 8'd50;

  typedef enum logic [1:0] {StIdle, StSelect, StIssue, StFinish} vm_state_e;

  // Invalid codes map to zero.
  function automatic logic [7:0] coin_value(input logic [3:0] code);
    logic [7:0] val;
    case (code)
      CodeOne:   val = ValOne;
      CodeFive:  val = ValFive;
      CodeTen:   val = ValTen;
      CodeFifty: val = ValFifty;
      default:   val = 8'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin stock for the change dispenser.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   dec, dec_idx      remove one coin from slot dec_idx (slot = code - 1)
//   refill, refill_code, refill_count
//                     add refill_count coins of refill_code; invalid codes ignored
//   nonzero           bit i set when slot i holds at least one coin
// Counters saturate at 2^INV_W - 1; a refill and a decrement of the same
// slot in one cycle combine before saturation.
module coin_inventory
  import vm_pkg::*;
#(
  parameter int unsigned INV_W    = 8,
  parameter int unsigned INV_INIT = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec,
  input  logic [1:0]           dec_idx,
  input  logic                 refill,
  input  logic [3:0]           refill_code,
  input  logic [7:0]           refill_count,
  output logic [NumDenoms-1:0] nonzero
);

  // Wide enough for a full counter plus a full refill without wrapping.
  localparam int unsigned SumW = INV_W + 9;
  localparam logic [SumW-1:0] InvMax = {9'd0, {INV_W{1'b1}}};

  logic [NumDenoms-1:0][INV_W-1:0] inv_q, inv_d;
  logic [NumDenoms-1:0][SumW-1:0]  sum;
  logic [NumDenoms-1:0][7:0]       add;
  logic [NumDenoms-1:0]            dec_hit;

  always_comb begin
    inv_d   = inv_q;
    sum     = '0;
    add     = '0;
    dec_hit = '0;
    for (int i = 0; i < NumDenoms; i++) begin
      add[i]     = (refill && refill_code == 4'(i + 1)) ? refill_count : 8'd0;
      dec_hit[i] = dec && (dec_idx == 2'(i));
      sum[i]     = {9'd0, inv_q[i]} + {{(INV_W + 1){1'b0}}, add[i]}
                   - {{(INV_W + 8){1'b0}}, dec_hit[i]};
      inv_d[i]   = (sum[i] > InvMax) ? {INV_W{1'b1}} : sum[i][INV_W-1:0];
      nonzero[i] = |inv_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= {NumDenoms{INV_W'(INV_INIT)}};
    end else begin
      inv_q <= inv_d;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: accepts a change amount and presents coin codes to
// the hopper one at a time, largest available denomination first.
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   change_valid/_amount/_ready   change request handshake (ready only in idle)
//   coin_out_valid/_code/_ack     coin presented to the hopper, held until ack
//   refill, refill_code, refill_count   inventory top-up, accepted any time
//   busy                          high whenever not idle
//   done, short, jam              one-cycle completion pulses (paid / no stock / ack timeout)
//   remaining, coins_paid         progress of the current or last request
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned INV_W       = 8,
  parameter int unsigned INV_INIT    = 10,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             change_valid,
  input  logic [7:0]       change_amount,
  output logic             change_ready,
  output logic             coin_out_valid,
  output logic [3:0]       coin_out_code,
  input  logic             coin_out_ack,
  input  logic             refill,
  input  logic [3:0]       refill_code,
  input  logic [7:0]       refill_count,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             jam,
  output logic [7:0]       remaining,
  output logic [INV_W-1:0] coins_paid
);

  localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);

  vm_state_e             state_q;
  logic [7:0]            remaining_q;
  logic [INV_W-1:0]      coins_paid_q;
  logic [3:0]            code_q;
  logic [TimerW-1:0]     timer_q;
  logic                  done_q, short_q, jam_q;

  logic [NumDenoms-1:0]  nonzero;
  logic                  sel_ok;
  logic [3:0]            sel_code;
  logic                  ack_fire;

  assign ack_fire = (state_q == StIssue) && coin_out_ack;

  coin_inventory #(
    .INV_W    (INV_W),
    .INV_INIT (INV_INIT)
  ) u_inv (
    .clk          (clk),
    .rst_n        (rst_n),
    .dec          (ack_fire),
    .dec_idx      (2'(code_q - 4'd1)),
    .refill       (refill),
    .refill_code  (refill_code),
    .refill_count (refill_count),
    .nonzero      (nonzero)
  );

  // Greedy pick: largest in-stock coin that does not overpay.
  always_comb begin
    sel_ok   = 1'b1;
    sel_code = CodeOne;
    if (nonzero[3] && remaining_q >= ValFifty) begin
      sel_code = CodeFifty;
    end else if (nonzero[2] && remaining_q >= ValTen) begin
      sel_code = CodeTen;
    end else if (nonzero[1] && remaining_q >= ValFive) begin
      sel_code = CodeFive;
    end else if (nonzero[0] && remaining_q >= ValOne) begin
      sel_code = CodeOne;
    end else begin
      sel_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      remaining_q  <= 8'd0;
      coins_paid_q <= '0;
      code_q       <= 4'd0;
      timer_q      <= '0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      jam_q        <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      short_q <= 1'b0;
      jam_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (change_valid) begin
            remaining_q  <= change_amount;
            coins_paid_q <= '0;
            state_q      <= StSelect;
          end
        end
        StSelect: begin
          if (remaining_q == 8'd0) begin
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else if (sel_ok) begin
            code_q  <= sel_code;
            timer_q <= '0;
            state_q <= StIssue;
          end else begin
            short_q <= 1'b1;
            state_q <= StFinish;
          end
        end
        StIssue: begin
          if (coin_out_ack) begin
            remaining_q  <= remaining_q - coin_value(code_q);
            coins_paid_q <= coins_paid_q + INV_W'(1);
            state_q      <= StSelect;
          end else if (timer_q == TimerW'(ACK_TIMEOUT - 1)) begin
            jam_q   <= 1'b1;
            state_q <= StFinish;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign change_ready   = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign coin_out_valid = (state_q == StIssue);
  assign coin_out_code  = code_q;
  assign done           = done_q;
  assign short          = short_q;
  assign jam            = jam_q;
  assign remaining      = remaining_q;
  assign coins_paid     = coins_paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  logic       clk;
  logic       rst_n;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       change_ready;
  logic       coin_out_valid;
  logic [3:0] coin_out_code;
  logic       coin_out_ack;
  logic       refill;
  logic [3:0] refill_code;
  logic [7:0] refill_count;
  logic       busy, done, short, jam;
  logic [7:0] remaining;
  logic [7:0] coins_paid;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  change_dispenser #(
    .INV_W       (8),
    .INV_INIT    (10),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .change_valid   (change_valid),
    .change_amount  (change_amount),
    .change_ready   (change_ready),
    .coin_out_valid (coin_out_valid),
    .coin_out_code  (coin_out_code),
    .coin_out_ack   (coin_out_ack),
    .refill         (refill),
    .refill_code    (refill_code),
    .refill_count   (refill_count),
    .busy           (busy),
    .done           (done),
    .short          (short),
    .jam            (jam),
    .remaining      (remaining),
    .coins_paid     (coins_paid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inv(input string tag, input int i1, input int i5, input int i10,
                           input int i50);
    chk({tag, "_inv1"}, 32'(dut.u_inv.inv_q[0]), i1);
    chk({tag, "_inv5"}, 32'(dut.u_inv.inv_q[1]), i5);
    chk({tag, "_inv10"}, 32'(dut.u_inv.inv_q[2]), i10);
    chk({tag, "_inv50"}, 32'(dut.u_inv.inv_q[3]), i50);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, change_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, coin_out_valid, 0);
    chk({tag, "_code"}, coin_out_code, 0);
    chk({tag, "_pulses"}, {done, short, jam}, 0);
    chk({tag, "_rem"}, remaining, 0);
    chk({tag, "_paid"}, coins_paid, 0);
    check_inv(tag, 10, 10, 10, 10);
  endtask

  task automatic push_n(input logic [3:0] code, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(code);
  endtask

  task automatic do_refill(input logic [3:0] code, input logic [7:0] cnt);
    @(negedge clk);
    refill = 1'b1; refill_code = code; refill_count = cnt;
    @(negedge clk);
    refill = 1'b0;
  endtask

  // kind: {done, short, jam}. ack_refill tops up 10 coins of code 3 on the first ack.
  task automatic do_request(input string tag, input logic [7:0] amt, input logic [2:0] kind,
                            input bit withhold, input bit ack_refill,
                            input int exp_paid, input int exp_rem);
    bit got = 0;
    bit rf_pending = ack_refill;
    int valid_cycles = 0;
    logic [3:0] e;
    @(negedge clk);
    change_valid = 1'b1; change_amount = amt;
    @(negedge clk);
    change_valid = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      coin_out_ack = 1'b0;
      refill       = 1'b0;
      if (done || short || jam) begin
        got = 1;
        chk({tag, "_kind"}, {done, short, jam}, kind);
        chk({tag, "_rem"}, remaining, exp_rem);
        chk({tag, "_paid"}, coins_paid, exp_paid);
      end else if (coin_out_valid) begin
        valid_cycles++;
        if (!withhold) begin
          if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_coin"}, coin_out_code, 0);
          end else begin
            e = exp_q.pop_front();
            chk({tag, "_code"}, coin_out_code, e);
          end
          coin_out_ack = 1'b1;
          if (rf_pending) begin
            refill = 1'b1; refill_code = 4'h3; refill_count = 8'd10;
            rf_pending = 0;
          end
        end
      end
    end
    chk({tag, "_pulse_seen"}, got, 1);
    if (withhold) chk({tag, "_timeout_len"}, valid_cycles, 16);
    @(negedge clk);
    chk({tag, "_pulse_drop"}, {done, short, jam}, 0);
    chk({tag, "_ready_back"}, change_ready, 1);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; change_valid = 1'b0; change_amount = 8'd0; coin_out_ack = 1'b0;
    refill = 1'b0; refill_code = 4'd0; refill_count = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-amount request timing; cycle N is the one presenting change_valid.
    change_valid = 1'b1; change_amount = 8'd0;
    @(negedge clk);
    change_valid = 1'b0;
    chk("zero_busy_n1", busy, 1);
    chk("zero_done_n1", done, 0);
    @(negedge clk);
    chk("zero_done_n2", done, 1);
    chk("zero_ready_n2", change_ready, 0);
    @(negedge clk);
    chk("zero_ready_n3", change_ready, 1);
    chk("zero_done_n3", done, 0);

    push_n(4'h4, 1); push_n(4'h3, 1); push_n(4'h2, 1); push_n(4'h1, 2);
    do_request("c67", 8'd67, 3'b100, 0, 0, 5, 0);
    check_inv("c67", 8, 9, 9, 9);

    // Empty the 50-coin slot.
    push_n(4'h4, 5);
    do_request("d250", 8'd250, 3'b100, 0, 0, 5, 0);
    push_n(4'h4, 4);
    do_request("d200", 8'd200, 3'b100, 0, 0, 4, 0);

    push_n(4'h3, 6); push_n(4'h2, 1); push_n(4'h1, 2);
    do_request("no50", 8'd67, 3'b100, 0, 0, 9, 0);
    check_inv("no50", 6, 8, 3, 0);

    // Leave a single 5-coin in stock.
    push_n(4'h3, 3);
    do_request("d30", 8'd30, 3'b100, 0, 0, 3, 0);
    push_n(4'h2, 7);
    do_request("d35", 8'd35, 3'b100, 0, 0, 7, 0);
    push_n(4'h1, 4);
    do_request("d4", 8'd4, 3'b100, 0, 0, 4, 0);
    push_n(4'h1, 2);
    do_request("d2", 8'd2, 3'b100, 0, 0, 2, 0);
    check_inv("drained", 0, 1, 0, 0);

    push_n(4'h2, 1);
    do_request("short7", 8'd7, 3'b010, 0, 0, 1, 2);
    check_inv("short7", 0, 0, 0, 0);

    do_refill(4'h3, 8'd5);
    do_request("jam10", 8'd10, 3'b001, 1, 0, 0, 10);
    check_inv("jam10", 0, 0, 5, 0);

    do_refill(4'h3, 8'd245);
    check_inv("fill250", 0, 0, 250, 0);
    push_n(4'h3, 1);
    do_request("satack", 8'd10, 3'b100, 0, 1, 1, 0);
    check_inv("satack", 0, 0, 255, 0);
    do_refill(4'h7, 8'd5);
    check_inv("badcode", 0, 0, 255, 0);

    // Second request while busy, then reset in the middle of a coin.
    @(negedge clk);
    change_valid = 1'b1; change_amount = 8'd20;
    @(negedge clk);
    change_amount = 8'd99;
    @(negedge clk);
    change_valid = 1'b0;
    chk("mid_valid", coin_out_valid, 1);
    chk("mid_code", coin_out_code, 4'h3);
    chk("mid_rem", remaining, 20);
    rst_n = 1'b0;
    #1;
    chk("async_valid_drop", coin_out_valid, 0);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {coin_out_valid, busy, done, short, jam}, 0);
      chk("post_rst_rem", remaining, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout engine at the output end of the vending machine's coin path. Coin detection maps an inserted coin code to a value; this block does the reverse. It accepts a change amount from the controller and pays it out as a sequence of coin codes to the hopper, largest denomination first. It tracks per-denomination inventory and reports a shortfall or a hopper jam.

## Interface
Parameters:
- INV_W, 8: width of each inventory counter and of coins_paid.
- INV_INIT, 10: per-denomination inventory loaded on reset.
- ACK_TIMEOUT, 16: cycles coin_out_valid may remain unacknowledged before a jam is declared.

Ports:
- clk, in, 1: system clock. Single clock domain.
- rst_n, in, 1: asynchronous active-low reset.
- change_valid, in, 1: change request strobe.
- change_amount, in, 8: change to pay, in currency units.
- change_ready, out, 1: high only in IDLE.
- coin_out_valid, out, 1: a coin is being presented to the hopper.
- coin_out_code, out, 4: code of the presented coin.
- coin_out_ack, in, 1: hopper has ejected the presented coin.
- refill, in, 1: add refill_count coins of refill_code.
- refill_code, in, 4: denomination being refilled.
- refill_count, in, 8: number of coins added.
- busy, out, 1: high whenever not in IDLE.
- done, out, 1: one-cycle pulse; the request is fully paid.
- short, out, 1: one-cycle pulse; inventory could not cover the remainder.
- jam, out, 1: one-cycle pulse; ack timeout.
- remaining, out, 8: unpaid amount of the current or last request.
- coins_paid, out, INV_W: coins ejected for the current or last request.

## Operation
- Denominations: code 4'h1 = 1, 4'h2 = 5, 4'h3 = 10, 4'h4 = 50.
- All other codes are invalid. A refill with an invalid code is ignored.
- FSM states: IDLE, SELECT, ISSUE, FINISH.
- IDLE:
  - On change_valid && change_ready: latch remaining = change_amount, clear coins_paid, go to SELECT.
  - change_valid in any other state is ignored; it is not queued.
- SELECT (1 cycle):
  - If remaining == 0: go to FINISH with done.
  - Otherwise choose the largest denomination whose value <= remaining and whose inventory > 0. Register its code and go to ISSUE.
  - If no denomination qualifies: go to FINISH with short.
- ISSUE:
  - coin_out_valid = 1 and coin_out_code is held stable until ack.
  - On coin_out_ack: remaining -= value, inventory[d] -= 1, coins_paid += 1, go to SELECT.
  - If ACK_TIMEOUT cycles pass without ack: go to FINISH with jam. Remaining and inventory are unchanged.
- FINISH (1 cycle): pulse exactly one of done, short or jam, then go to IDLE.
- coin_out_ack outside ISSUE is ignored.
- Refill is accepted in every state and adds to inventory with saturation at 2^INV_W − 1.
- A refill and a decrement of the same denomination in the same cycle give inventory = sat(inv + count − 1).
- A refill that lands during SELECT affects the next SELECT, not the current one.
- remaining and coins_paid hold their values in IDLE until the next accepted request.

## Timing
- Reset values:
  - Outputs: coin_out_valid, busy, done, short and jam are 0.
  - change_ready is 1 (state IDLE).
  - coin_out_code, remaining and coins_paid are 0.
  - Every inventory counter is INV_INIT.
- Reset mid-payout aborts immediately: coin_out_valid drops asynchronously and no pulse is emitted.
- Request accepted at edge N: busy is high at N+1 (SELECT) and coin_out_valid is high at N+2.
- Each coin costs 2 cycles minimum: ISSUE with same-cycle ack, then SELECT.
- The timeout counter starts when ISSUE is entered and resets on every entry. A jam is flagged on the ACK_TIMEOUT-th cycle without ack.
- A zero-amount request: done pulses at N+2 and change_ready returns at N+3.

## Structure
- Shared package vm_pkg holds:
  - the coin code constants and coin value constants;
  - the code-to-value function, also used by coin detection;
  - the state enum.
- Sub-module coin_inventory holds the four saturating counters. It has a decrement port (index) and a refill port, and outputs a nonzero mask.
- Greedy selection, the FSM and the timeout counter live in change_dispenser.

## Test plan
- Inventory 10 each, change 67, immediate acks → codes 4, 3, 2, 1, 1; done; coins_paid = 5; remaining = 0; the 50-coin count drops to 9.
- 50-coin inventory at 0, change 67 → six code 3, one code 2, two code 1; coins_paid = 9; done.
- Only one 5-coin in stock (all others 0), change 7 → one code 2, then short; remaining = 2; coins_paid = 1.
- Ack withheld for 16 cycles on the first coin of change 10 → jam pulse; remaining = 10; inventory unchanged; change_ready returns.
- 10-coin inventory at 250, refill 10 of code 3 during an ack of code 3 → inventory = 255 (saturated). Refill code 4'h7 → no change.
- change_valid pulsed while busy, then rst_n asserted mid-ISSUE → second request not paid; all outputs at reset values; inventory = INV_INIT.
